demux_1to2: RTL and testbench
=============================

# demux_1to2

Registered 1-to-2 demultiplexer: one data input is steered to one of two outputs, selected by `Sel`, and the deselected output is forced to zero. Outputs are registered on `clk` with a synchronous active-high reset. Per-output valid flags let downstream logic tell a routed zero from an idle output. The block is a generic datapath steering primitive used wherever one source feeds one of two consumers.

## Interface
- `WIDTH`, default 1: data width of `I`, `Y0` and `Y1`.
- `IDLE_ZERO`, default 1: 1 drives the deselected output to 0; 0 makes the deselected output hold its last value.
- `clk`  in  1  rising-edge clock; the only clock in the block.
- `rst`  in  1  reset; synchronous and active-high.
- `en`  in  1  capture enable; when 0, no new routing takes place.
- `I`  in  WIDTH  data input.
- `Sel`  in  1  route select: 0 selects `Y0`, 1 selects `Y1`.
- `Y0`  out  WIDTH  registered output, channel 0.
- `Y1`  out  WIDTH  registered output, channel 1.
- `Y0_vld`  out  1  `Y0` was loaded from `I` at the last edge.
- `Y1_vld`  out  1  `Y1` was loaded from `I` at the last edge.
- Port order at instantiation: `clk`, `rst`, `en`, `I`, `Sel`, `Y0`, `Y1`, `Y0_vld`, `Y1_vld`.

## Operation
- All outputs are flops; there is no combinational path from any input to any output.
- At a rising edge with `rst`=1, all outputs go to 0: `Y0`=0, `Y1`=0, `Y0_vld`=0, `Y1_vld`=0. `rst` has priority over `en`.
- Rising edge with `rst`=0, `en`=1, `Sel`=0:
  - `Y0`<=`I`, `Y0_vld`<=1, `Y1_vld`<=0.
  - `Y1`<=0 if `IDLE_ZERO`=1; otherwise `Y1` holds.
- Rising edge with `rst`=0, `en`=1, `Sel`=1:
  - `Y1`<=`I`, `Y1_vld`<=1, `Y0_vld`<=0.
  - `Y0`<=0 if `IDLE_ZERO`=1; otherwise `Y0` holds.
- Rising edge with `rst`=0, `en`=0:
  - `Y0` and `Y1` hold.
  - `Y0_vld` and `Y1_vld` go to 0.
- `Y0_vld` and `Y1_vld` are never 1 at the same time.
- With `IDLE_ZERO`=1, at most one of `Y0`/`Y1` is nonzero at any time.
- Data passes through unmodified: no arithmetic, no width change, bit-for-bit copy of `I`.
- X/Z on `Sel` while `en`=1 is a protocol violation. The bench flags it; RTL behaviour in that case is not specified.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Back-to-back routing is supported every cycle. `Sel` may change every cycle with no bubble.
- Reset asserted mid-stream clears all outputs at that edge. The first post-reset capture occurs at the first edge with `rst`=0 and `en`=1.
- Changes to `I` or `Sel` between edges have no effect on the outputs.

## Test plan
- Reset: `rst`=1 for 2 cycles with `I`=1, `Sel`=1, `en`=1 -> `Y0`=0, `Y1`=0, both valid flags 0.
- Route to channel 0: `I`=1, `Sel`=0, `en`=1, one edge -> `Y0`=1, `Y1`=0, `Y0_vld`=1, `Y1_vld`=0.
- Route to channel 1: next cycle `I`=1, `Sel`=1 -> `Y0`=0, `Y1`=1, `Y0_vld`=0, `Y1_vld`=1.
- Zero data: `I`=0 with `Sel`=0, then with `Sel`=1 -> outputs all 0. The valid flag of the selected channel is still 1 in each cycle.
- Enable low: after routing `I`=1 to `Y1`, set `en`=0 and `I`=0 -> `Y1` stays 1, both valid flags 0. Then `rst`=1 for one edge -> all outputs 0.
- `WIDTH`=8, `IDLE_ZERO`=0: route 0xA5 to `Y0`, then 0x3C to `Y1` -> `Y0`=0xA5 held, `Y1`=0x3C, `Y1_vld`=1.

Source files
------------

// File: rtl/demux_1to2.sv
// demux_1to2
//   Registered 1-to-2 steering primitive. One data input is copied, unmodified,
//   into whichever output channel Sel selects. A per-channel valid flag marks
//   the channel that was loaded at the last edge, so a routed zero can be told
//   apart from an idle output.
//
// Parameters
//   WIDTH      data width of I, Y0 and Y1
//   IDLE_ZERO  1: the deselected channel is cleared on every capture
//              0: the deselected channel keeps its last value
//
// Ports
//   clk     in   1      rising-edge clock, only clock in the block
//   rst     in   1      synchronous active-high reset, dominates en
//   en      in   1      capture enable; 0 holds data and drops both valid flags
//   I       in   WIDTH  data input
//   Sel     in   1      0 routes to Y0, 1 routes to Y1
//   Y0      out  WIDTH  registered channel 0 data
//   Y1      out  WIDTH  registered channel 1 data
//   Y0_vld  out  1      Y0 was loaded from I at the last edge
//   Y1_vld  out  1      Y1 was loaded from I at the last edge
//
// Every output is a flop; nothing combinational reaches the ports.

module demux_1to2 #(
   parameter int unsigned WIDTH     = 1,
   parameter bit          IDLE_ZERO = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] I,
   input  logic             Sel,
   output logic [WIDTH-1:0] Y0,
   output logic [WIDTH-1:0] Y1,
   output logic             Y0_vld,
   output logic             Y1_vld
);

   // Next-value selection is kept in one comb block so the register block
   // below stays a plain load; this keeps the hold paths obvious.
   logic [WIDTH-1:0] y0_nxt;
   logic [WIDTH-1:0] y1_nxt;
   logic             y0_vld_nxt;
   logic             y1_vld_nxt;

   always_comb begin
      y0_nxt     = Y0;
      y1_nxt     = Y1;
      y0_vld_nxt = 1'b0;
      y1_vld_nxt = 1'b0;
      if (en) begin
         if (Sel) begin
            y1_nxt     = I;
            y1_vld_nxt = 1'b1;
            if (IDLE_ZERO) begin
               y0_nxt = '0;
            end
         end else begin
            y0_nxt     = I;
            y0_vld_nxt = 1'b1;
            if (IDLE_ZERO) begin
               y1_nxt = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Y0     <= '0;
         Y1     <= '0;
         Y0_vld <= 1'b0;
         Y1_vld <= 1'b0;
      end else begin
         Y0     <= y0_nxt;
         Y1     <= y1_nxt;
         Y0_vld <= y0_vld_nxt;
         Y1_vld <= y1_vld_nxt;
      end
   end

endmodule

// File: tb/tb_demux_1to2.sv
module tb_demux_1to2;

   typedef struct packed {
      logic [7:0] y0;
      logic [7:0] y1;
      logic       v0;
      logic       v1;
      logic [7:0] id;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance a: WIDTH=1, IDLE_ZERO=1
   logic       rst_a = 1'b1, en_a = 1'b0, sel_a = 1'b0;
   logic [0:0] i_a = '0;
   logic [0:0] y0_a, y1_a;
   logic       y0_vld_a, y1_vld_a;

   // instance b: WIDTH=8, IDLE_ZERO=0
   logic       rst_b = 1'b1, en_b = 1'b0, sel_b = 1'b0;
   logic [7:0] i_b = '0;
   logic [7:0] y0_b, y1_b;
   logic       y0_vld_b, y1_vld_b;

   demux_1to2 #(.WIDTH(1), .IDLE_ZERO(1'b1)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .I(i_a), .Sel(sel_a),
      .Y0(y0_a), .Y1(y1_a), .Y0_vld(y0_vld_a), .Y1_vld(y1_vld_a)
   );

   demux_1to2 #(.WIDTH(8), .IDLE_ZERO(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .I(i_b), .Sel(sel_b),
      .Y0(y0_b), .Y1(y1_b), .Y0_vld(y0_vld_b), .Y1_vld(y1_vld_b)
   );

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic cmp(input string name, input int id, input logic [7:0] act,
                      input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s vec%0d: got 0x%0h, expected 0x%0h", name, id, act, req);
      end
   endtask

   // Drive on the falling edge; the expected result of the following rising
   // edge goes into the queue for the monitor.
   task automatic step_a(input logic r, input logic e, input logic d, input logic s,
                         input logic e0, input logic e1, input logic v0, input logic v1,
                         input int id);
      exp_t x;
      @(negedge clk);
      rst_a = r; en_a = e; i_a = d; sel_a = s;
      x.y0 = {7'd0, e0}; x.y1 = {7'd0, e1}; x.v0 = v0; x.v1 = v1; x.id = 8'(id);
      q_a.push_back(x);
   endtask

   task automatic step_b(input logic r, input logic e, input logic [7:0] d, input logic s,
                         input logic [7:0] e0, input logic [7:0] e1, input logic v0,
                         input logic v1, input int id);
      exp_t x;
      @(negedge clk);
      rst_b = r; en_b = e; i_b = d; sel_b = s;
      x.y0 = e0; x.y1 = e1; x.v0 = v0; x.v1 = v1; x.id = 8'(id);
      q_b.push_back(x);
   endtask

   // Monitors: sample 1 time unit after each rising edge.
   always @(posedge clk) begin
      exp_t x;
      if (!rst_a && en_a && $isunknown(sel_a)) begin
         n_err++;
         $display("FAIL sel_a protocol: Sel is X/Z while en=1");
      end
      #1;
      if (q_a.size() > 0) begin
         x = q_a.pop_front();
         cmp("a_y0",     int'(x.id), {7'd0, y0_a},     x.y0);
         cmp("a_y1",     int'(x.id), {7'd0, y1_a},     x.y1);
         cmp("a_y0_vld", int'(x.id), {7'd0, y0_vld_a}, {7'd0, x.v0});
         cmp("a_y1_vld", int'(x.id), {7'd0, y1_vld_a}, {7'd0, x.v1});
      end
   end

   always @(posedge clk) begin
      exp_t x;
      if (!rst_b && en_b && $isunknown(sel_b)) begin
         n_err++;
         $display("FAIL sel_b protocol: Sel is X/Z while en=1");
      end
      #1;
      if (q_b.size() > 0) begin
         x = q_b.pop_front();
         cmp("b_y0",     int'(x.id), y0_b,             x.y0);
         cmp("b_y1",     int'(x.id), y1_b,             x.y1);
         cmp("b_y0_vld", int'(x.id), {7'd0, y0_vld_b}, {7'd0, x.v0});
         cmp("b_y1_vld", int'(x.id), {7'd0, y1_vld_b}, {7'd0, x.v1});
      end
   end

   initial begin
      //      rst  en   I    Sel   Y0   Y1   v0   v1   id
      step_a(1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 0);   // reset, 2 cycles
      step_a(1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 1);
      step_a(1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0, 2);   // route to Y0
      step_a(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1, 3);   // route to Y1
      step_a(1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 4);   // zero data to Y0
      step_a(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, 5);   // zero data to Y1
      step_a(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1, 6);
      step_a(1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 7);   // en low: hold
      step_a(1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 8);
      step_a(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 9);   // reset clears
      step_a(1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 10);  // no capture yet
      step_a(1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0, 11);  // first capture
      step_a(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1, 12);  // back-to-back
      step_a(1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0, 13);
      step_a(1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 14);  // rst beats en
      step_a(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 15);

      //      rst  en   I      Sel   Y0     Y1     v0   v1   id
      step_b(1'b1,1'b1,8'hFF,1'b1, 8'h00,8'h00,1'b0,1'b0, 20);
      step_b(1'b0,1'b1,8'hA5,1'b0, 8'hA5,8'h00,1'b1,1'b0, 21);
      step_b(1'b0,1'b1,8'h3C,1'b1, 8'hA5,8'h3C,1'b0,1'b1, 22); // Y0 held
      step_b(1'b0,1'b0,8'hFF,1'b0, 8'hA5,8'h3C,1'b0,1'b0, 23);
      step_b(1'b0,1'b1,8'h5A,1'b0, 8'h5A,8'h3C,1'b1,1'b0, 24);
      step_b(1'b0,1'b1,8'hC3,1'b1, 8'h5A,8'hC3,0,1,          25);
      step_b(1'b0,1'b1,8'h00,1'b0, 8'h00,8'hC3,1'b1,1'b0, 26);
      step_b(1'b1,1'b1,8'h81,1'b0, 8'h00,8'h00,1'b0,1'b0, 27);

      begin
         int budget;
         budget = 0;
         while ((q_a.size() > 0 || q_b.size() > 0) && budget < 20) begin
            @(negedge clk);
            budget++;
         end
         if (q_a.size() > 0 || q_b.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0", q_a.size(), q_b.size());
         end
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
